// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the 3-digit seven-segment scan controller.
package sevenseg_pkg;

  // Conversion FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Digit slot indices used by the scanner
  localparam logic [1:0] DIG_ONES = 2'd0;
  localparam logic [1:0] DIG_TENS = 2'd1;
  localparam logic [1:0] DIG_HUND = 2'd2;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;

  // Anode patterns, active-low, one digit enabled at a time
  localparam logic [2:0] AN_OFF  = 3'b111;
  localparam logic [2:0] AN_ONES = 3'b110;
  localparam logic [2:0] AN_TENS = 3'b101;
  localparam logic [2:0] AN_HUND = 3'b011;

  // Double-dabble correction: a BCD nibble of 5 or more gets +3 before the shift
  function automatic logic [3:0] add3_adj(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational BCD-to-seven-segment decoder with a blank override.
// Codes 10..15 decode to an all-off pattern.
module seg7_digit_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  // Pattern lookup; blank forces every segment off
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// 3-digit multiplexed seven-segment controller.
// Handshake: a value transfers on a rising edge where load_valid and
// load_ready are both high; load_ready is high only while the converter is
// idle, and load_valid is ignored whenever load_ready is low.
// The 8-bit value is converted to BCD with one shift-add-3 step per cycle,
// then committed atomically to the display registers. The scanner runs
// independently of the converter and never sees partial results.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] value,
  input  logic       blank_lz,
  output logic       done,
  output logic [6:0] seg,
  output logic [2:0] an
);

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(SCAN_DIV - 1);

  // Converter state
  state_t      state;
  logic [7:0]  shreg;
  logic [9:0]  scratch;   // {hund[1:0], tens[3:0], ones[3:0]}
  logic [2:0]  bit_cnt;
  logic [3:0]  tens_adj;
  logic [3:0]  ones_adj;

  // Committed display digits
  logic [1:0]  hund;
  logic [3:0]  tens;
  logic [3:0]  ones;

  // Scanner state
  logic [CNT_W-1:0] presc;
  logic [1:0]       dig_idx;

  // Muxed digit feeding the decoder
  logic [3:0]  cur_digit;
  logic        cur_blank;
  logic [2:0]  cur_an;
  logic [6:0]  seg_next;

  // Ready whenever the converter is idle
  always_comb begin
    load_ready = (state == ST_IDLE);
  end

  // Add-3 correction on the BCD nibbles; hundreds never exceeds 2 for 8-bit input
  always_comb begin
    tens_adj = add3_adj(scratch[7:4]);
    ones_adj = add3_adj(scratch[3:0]);
  end

  // Accept / convert / commit sequencing and the committed display registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      shreg   <= 8'd0;
      scratch <= 10'd0;
      bit_cnt <= 3'd0;
      hund    <= 2'd0;
      tens    <= 4'd0;
      ones    <= 4'd0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_valid && load_ready) begin
            shreg   <= value;
            scratch <= 10'd0;
            bit_cnt <= 3'd0;
            state   <= ST_CONV;
          end
        end
        ST_CONV: begin
          scratch <= {scratch[8], tens_adj, ones_adj, shreg[7]};
          shreg   <= {shreg[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          hund  <= scratch[9:8];
          tens  <= scratch[7:4];
          ones  <= scratch[3:0];
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Prescaler and digit index: each slot stays active for SCAN_DIV cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      dig_idx <= DIG_ONES;
    end else if (presc == PRESC_LAST) begin
      presc   <= '0;
      dig_idx <= (dig_idx == DIG_HUND) ? DIG_ONES : (dig_idx + 2'd1);
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Select the active digit, its leading-zero blank and its anode pattern
  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b1;
    cur_an    = AN_OFF;
    case (dig_idx)
      DIG_ONES: begin
        cur_digit = ones;
        cur_blank = 1'b0;
        cur_an    = AN_ONES;
      end
      DIG_TENS: begin
        cur_digit = tens;
        cur_blank = blank_lz && (hund == 2'd0) && (tens == 4'd0);
        cur_an    = AN_TENS;
      end
      DIG_HUND: begin
        cur_digit = {2'b00, hund};
        cur_blank = blank_lz && (hund == 2'd0);
        cur_an    = AN_HUND;
      end
      default: begin
        cur_digit = 4'd0;
        cur_blank = 1'b1;
        cur_an    = AN_OFF;
      end
    endcase
  end

  seg7_digit_decode u_decode (
    .bcd   (cur_digit),
    .blank (cur_blank),
    .seg   (seg_next)
  );

  // Register seg and an together so the pins change on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_BLANK;
      an  <= AN_OFF;
    end else begin
      seg <= seg_next;
      an  <= cur_an;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl with a short scan period.
module tb_sevenseg_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int CNT_W    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] value = 8'd0;
  logic       blank_lz = 1'b0;
  logic       load_ready;
  logic       done;
  logic [6:0] seg;
  logic [2:0] an;

  int total = 0;
  int bad   = 0;

  // Scoreboard: expected committed digits {h,t,o} and the edge of their done pulse
  logic [11:0] exp_q[$];
  int          exp_edge_q[$];

  // Reference model state
  int         cyc      = 0;     // rising edges so far
  int         n_run    = 0;     // edges since the last reset edge
  int         acc_edge = -100;  // edge of the most recent accept
  logic       prev_rst   = 1'b1;
  logic       prev_blank = 1'b0;
  logic [3:0] m_h = 4'd0;
  logic [3:0] m_t = 4'd0;
  logic [3:0] m_o = 4'd0;

  sevenseg_scan_ctrl #(
    .SCAN_DIV (SCAN_DIV),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .value      (value),
    .blank_lz   (blank_lz),
    .done       (done),
    .seg        (seg),
    .an         (an)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, cyc);
    end
  endtask

  // Standard seven-segment glyphs {g,f,e,d,c,b,a}
  function automatic logic [6:0] ref_seg(input int d, input bit blank);
    logic [6:0] tbl [0:9];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (blank || d < 0 || d > 9) return 7'h00;
    return tbl[d];
  endfunction

  // Monitor: compare outputs after each edge, predict accepts for the next edge
  always @(negedge clk) begin
    int         slot;
    int         dig;
    int         iv;
    bit         blk;
    logic [2:0] e_an;
    logic       e_done;
    logic       e_ready;
    logic [11:0] d;
    cyc++;
    e_ready = 1'b1;
    if (prev_rst) begin
      exp_q.delete();
      exp_edge_q.delete();
      n_run    = 0;
      acc_edge = -100;
      m_h = 4'd0; m_t = 4'd0; m_o = 4'd0;
      check("rst_an",    32'(an),         32'(3'b111));
      check("rst_seg",   32'(seg),        32'(7'h00));
      check("rst_done",  32'(done),       32'(1'b0));
      check("rst_ready", 32'(load_ready), 32'(1'b1));
    end else begin
      n_run++;
      slot = ((n_run - 1) / SCAN_DIV) % 3;
      if (slot == 0) begin
        dig = int'(m_o); blk = 1'b0; e_an = 3'b110;
      end else if (slot == 1) begin
        dig = int'(m_t); blk = prev_blank && (m_h == 0) && (m_t == 0); e_an = 3'b101;
      end else begin
        dig = int'(m_h); blk = prev_blank && (m_h == 0); e_an = 3'b011;
      end
      check("an",  32'(an),  32'(e_an));
      check("seg", 32'(seg), 32'(ref_seg(dig, blk)));
      e_done = (exp_edge_q.size() > 0) && (exp_edge_q[0] == cyc);
      check("done", 32'(done), 32'(e_done));
      if (e_done) begin
        d = exp_q.pop_front();
        void'(exp_edge_q.pop_front());
        m_h = d[11:8]; m_t = d[7:4]; m_o = d[3:0];
      end
      e_ready = !(cyc >= acc_edge && cyc <= acc_edge + 8);
      check("ready", 32'(load_ready), 32'(e_ready));
    end
    if (!rst && load_valid && e_ready) begin
      iv = int'(value);
      acc_edge = cyc + 1;
      exp_q.push_back({4'(iv / 100), 4'((iv / 10) % 10), 4'(iv % 10)});
      exp_edge_q.push_back(cyc + 10);
    end
    prev_rst   = rst;
    prev_blank = blank_lz;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] v);
    value      = v;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  // Stimulus
  initial begin
    logic [7:0] edge_vals [0:7];
    edge_vals = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd199, 8'd200, 8'd255};

    // Reset held two cycles, then scan the zero display
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(15);
    blank_lz = 1'b1;
    wait_cycles(15);

    // Full-scale value without blanking
    blank_lz = 1'b0;
    send(8'd255);
    wait_cycles(20);

    // Small value with blanking, then blanking released
    blank_lz = 1'b1;
    send(8'd7);
    wait_cycles(20);
    blank_lz = 1'b0;
    wait_cycles(14);

    // Zero tens digit under a nonzero hundreds digit
    blank_lz = 1'b1;
    send(8'd208);
    wait_cycles(20);

    // Digit-boundary values
    for (int i = 0; i < 8; i++) begin
      blank_lz = i[0];
      send(edge_vals[i]);
      wait_cycles(14);
    end

    // load_valid held high with a new value every cycle
    load_valid = 1'b1;
    for (int i = 0; i < 35; i++) begin
      value = 8'($urandom_range(0, 255));
      step();
    end
    load_valid = 1'b0;
    wait_cycles(20);

    // Reset in the middle of a conversion
    blank_lz = 1'b0;
    send(8'd255);
    wait_cycles(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_cycles(20);

    // Random traffic with occasional resets
    for (int i = 0; i < 150; i++) begin
      blank_lz   = 1'($urandom_range(0, 1));
      load_valid = ($urandom_range(0, 2) != 0);
      value      = 8'($urandom_range(0, 255));
      rst        = ($urandom_range(0, 50) == 0);
      step();
    end
    rst        = 1'b0;
    load_valid = 1'b0;
    wait_cycles(30);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
